// File: rtl/sc_median_stream.sv
// Streaming KxK majority (stochastic median) filter over one bit-plane frame.
// One image row per handshake; rows near the frame edge are emitted from a short FLUSH phase.
module sc_median_stream #(
    parameter int N      = 32,
    parameter int M      = 32,
    parameter int K      = 3,
    parameter int BORDER = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_row,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_row,
    output logic         out_last
);
    localparam int H    = (K - 1) / 2;
    localparam int RC_W = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t          state_r;
    logic [RC_W-1:0] rc_r;
    logic [1:0]      fl_cnt_r;
    logic            started_r;
    logic [N-1:0]    lb_r [0:K-2];

    logic [N-1:0]    win_s [0:K-1];
    logic [N-1:0]    ctr_s;
    logic [N-1:0]    filt_s;
    logic [N-1:0]    run_row_s;
    logic [N-1:0]    fl_row_s;
    logic            acc_s;
    logic            xfer_s;
    logic            fl_ld_s;

    function automatic logic majority(input logic [K*K-1:0] w);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < K*K; i++) begin
            cnt = cnt + {31'd0, w[i]};
        end
        return (cnt > 32'((K*K)/2));
    endfunction

    function automatic logic [N-1:0] border_row(input logic [N-1:0] r);
        return (BORDER != 0) ? {N{1'b0}} : r;
    endfunction

    // Window row 0 is the row arriving now; deeper rows come from the line buffer.
    assign win_s[0] = in_row;
    for (genvar i = 1; i < K; i++) begin : g_win
        assign win_s[i] = lb_r[i-1];
    end
    assign ctr_s = lb_r[H-1];

    for (genvar c = 0; c < N; c++) begin : g_col
        if (c < H || c >= N - H) begin : g_edge
            assign filt_s[c] = (BORDER != 0) ? 1'b0 : ctr_s[c];
        end else begin : g_core
            logic [K*K-1:0] tap_s;
            for (genvar i = 0; i < K; i++) begin : g_tap
                assign tap_s[i*K +: K] = win_s[i][c-H +: K];
            end
            assign filt_s[c] = majority(tap_s);
        end
    end

    // Rows 0..H-1 of the frame are border rows even though they leave during RUN.
    assign run_row_s = (int'(rc_r) < 2*H) ? border_row(ctr_s) : filt_s;
    assign fl_row_s  = border_row((fl_cnt_r == 2'd0) ? lb_r[H-1] : lb_r[0]);

    assign in_ready = started_r && (state_r == RUN) && (!out_valid || out_ready);
    assign acc_s    = in_valid && in_ready;
    assign xfer_s   = out_valid && out_ready;
    assign fl_ld_s  = (state_r == FLUSH) && (!out_valid || out_ready);

    // Frame control, line buffer shift and the registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= RUN;
            rc_r      <= {RC_W{1'b0}};
            fl_cnt_r  <= 2'd0;
            started_r <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= {N{1'b0}};
            out_last  <= 1'b0;
            for (int i = 0; i < K-1; i++) begin
                lb_r[i] <= {N{1'b0}};
            end
        end else begin
            started_r <= 1'b1;
            if (xfer_s) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                RUN: begin
                    if (acc_s) begin
                        lb_r[0] <= in_row;
                        for (int i = 1; i < K-1; i++) begin
                            lb_r[i] <= lb_r[i-1];
                        end
                        if (int'(rc_r) >= H) begin
                            out_row   <= run_row_s;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                        end
                        if (rc_r == RC_W'(M-1)) begin
                            state_r  <= FLUSH;
                            fl_cnt_r <= 2'd0;
                        end else begin
                            rc_r <= rc_r + {{(RC_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FLUSH: begin
                    if (fl_ld_s) begin
                        out_row   <= fl_row_s;
                        out_valid <= 1'b1;
                        out_last  <= (fl_cnt_r == 2'(H-1));
                        if (fl_cnt_r == 2'(H-1)) begin
                            state_r <= RUN;
                            rc_r    <= {RC_W{1'b0}};
                        end else begin
                            fl_cnt_r <= fl_cnt_r + 2'd1;
                        end
                    end
                end
                default: state_r <= RUN;
            endcase
        end
    end
endmodule
